pwm_8bit: RTL and testbench

8-bit PWM generator that consumes the free-running count `q` of the 8-bit up-counter and turns it into a pulse-width-modulated output. The duty value is loaded over a valid/ready handshake into a shadow register and becomes active only at a period boundary, so the output never glitches mid-period. An optional dead-band stage adds a complementary low-side output for half-bridge drive.

---
 rtl/pwm_8bit.sv | 133 +++++++++++++
 tb/tb_pwm_8bit.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_8bit.sv
// 8-bit PWM generator with a handshake-loaded duty shadow applied only at period boundaries.
// Define PWM_DEADTIME_EN to add a dead band between pwm_out and the complementary pwm_n.
module pwm_8bit #(
    parameter logic [7:0]  DUTY_INIT = 8'h00,
    parameter int unsigned DEADTIME  = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] count,
    input  logic [7:0] duty_in,
    input  logic       duty_valid,
    output logic       duty_ready,
    output logic       pwm_out,
    output logic       pwm_n,
    output logic       period_start
);

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] prev_count_q;
    logic [7:0] duty_active_q, duty_active_d;
    logic [7:0] duty_shadow_q, duty_shadow_d;
    logic       ready_q, ready_d;
    logic       pwm_out_q, pwm_out_d;
    logic       pwm_n_q, pwm_n_d;
    logic       period_start_q;
    logic       boundary_s;
    logic       raw_s;

    // A held-at-zero counter fires only once because prev_count then also reads zero.
    assign boundary_s = (count == 8'h00) && (prev_count_q != 8'h00);
    assign raw_s      = (count < duty_active_q);

    // Shadow handshake and period-aligned duty update.
    always_comb begin
        state_d       = state_q;
        duty_active_d = duty_active_q;
        duty_shadow_d = duty_shadow_q;
        case (state_q)
            IDLE: begin
                if (duty_valid && ready_q) begin
                    duty_shadow_d = duty_in;
                    state_d       = PENDING;
                end else begin
                    state_d       = IDLE;
                end
            end
            PENDING: begin
                if (boundary_s) begin
                    duty_active_d = duty_shadow_q;
                    state_d       = IDLE;
                end else begin
                    state_d       = PENDING;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        ready_d = (state_d == IDLE);
    end

`ifdef PWM_DEADTIME_EN
    localparam logic [3:0] DEAD_CYC = DEADTIME[3:0];

    logic       raw_prev_q;
    logic       hist_vld_q;
    logic [3:0] run_q, run_d;

    // run_d = number of immediately preceding cycles with the same raw level (saturating).
    always_comb begin
        if (hist_vld_q && (raw_s == raw_prev_q)) begin
            run_d = (run_q == 4'hF) ? 4'hF : (run_q + 4'd1);
        end else begin
            run_d = 4'd0;
        end
        pwm_out_d = raw_s && (run_d >= DEAD_CYC);
        pwm_n_d   = !raw_s && (run_d >= DEAD_CYC);
    end

    // Dead-band history registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            raw_prev_q <= 1'b0;
            hist_vld_q <= 1'b0;
            run_q      <= 4'd0;
        end else begin
            raw_prev_q <= raw_s;
            hist_vld_q <= 1'b1;
            run_q      <= run_d;
        end
    end
`else
    // Plain complementary drive.
    always_comb begin
        pwm_out_d = raw_s;
        pwm_n_d   = ~raw_s;
    end
`endif

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            prev_count_q   <= 8'h00;
            duty_active_q  <= DUTY_INIT;
            duty_shadow_q  <= 8'h00;
            ready_q        <= 1'b0;
            pwm_out_q      <= 1'b0;
            pwm_n_q        <= 1'b0;
            period_start_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            prev_count_q   <= count;
            duty_active_q  <= duty_active_d;
            duty_shadow_q  <= duty_shadow_d;
            ready_q        <= ready_d;
            pwm_out_q      <= pwm_out_d;
            pwm_n_q        <= pwm_n_d;
            period_start_q <= boundary_s;
        end
    end

    assign duty_ready   = ready_q;
    assign pwm_out      = pwm_out_q;
    assign pwm_n        = pwm_n_q;
    assign period_start = period_start_q;

endmodule

// File: tb/tb_pwm_8bit.sv
// Self-checking bench for pwm_8bit: per-cycle model comparison plus per-period literal counts.
`timescale 1ns/1ps
module tb_pwm_8bit;

`ifdef PWM_DEADTIME_EN
    localparam int DT = 4;
`else
    localparam int DT = 0;
`endif

    logic       clk;
    logic       reset;
    logic [7:0] count;
    logic [7:0] duty_in;
    logic       duty_valid;
    logic       duty_ready;
    logic       pwm_out;
    logic       pwm_n;
    logic       period_start;

    int errors = 0;
    int checks = 0;
    int acc_hi, acc_n, acc_ps;
    logic cmp_en = 1'b0;

    pwm_8bit #(.DUTY_INIT(8'h40), .DEADTIME(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .count        (count),
        .duty_in      (duty_in),
        .duty_valid   (duty_valid),
        .duty_ready   (duty_ready),
        .pwm_out      (pwm_out),
        .pwm_n        (pwm_n),
        .period_start (period_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Expected number of high cycles for a contiguous raw phase of n counts.
    function automatic int lit(input int n);
        lit = (n > DT) ? (n - DT) : 0;
    endfunction

    // ---------------- behavioural model ----------------
    logic [7:0]  m_duty, m_shadow, m_prev;
    logic        m_pend;
    logic [15:0] m_hist;
    int          m_nv;
    logic        e_pwm, e_n, e_ps, e_rdy;
    logic        m_raw, m_bnd;

    assign m_raw = (count < m_duty);
    assign m_bnd = (count == 8'h00) && (m_prev != 8'h00);

    // True when the last DT samples since reset all equal the current raw level.
    function automatic logic dead_ok(input logic [15:0] h, input int nv, input logic r);
        dead_ok = (nv >= DT);
        for (int i = 0; i < DT; i++) begin
            if (h[i] != r) dead_ok = 1'b0;
        end
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_duty   <= 8'h40;
            m_shadow <= 8'h00;
            m_prev   <= 8'h00;
            m_pend   <= 1'b0;
            m_hist   <= 16'h0000;
            m_nv     <= 0;
            e_pwm    <= 1'b0;
            e_n      <= 1'b0;
            e_ps     <= 1'b0;
            e_rdy    <= 1'b0;
        end else begin
            e_pwm  <= m_raw && dead_ok(m_hist, m_nv, m_raw);
            e_n    <= !m_raw && dead_ok(m_hist, m_nv, m_raw);
            e_ps   <= m_bnd;
            m_prev <= count;
            m_hist <= {m_hist[14:0], m_raw};
            m_nv   <= (m_nv < 16) ? m_nv + 1 : m_nv;
            if (m_pend && m_bnd) begin
                m_duty <= m_shadow;
                m_pend <= 1'b0;
                e_rdy  <= 1'b1;
            end else if (!m_pend && duty_valid && e_rdy) begin
                m_shadow <= duty_in;
                m_pend   <= 1'b1;
                e_rdy    <= 1'b0;
            end else begin
                e_rdy <= !m_pend;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("cyc_pwm_out", int'(pwm_out), int'(e_pwm));
            check("cyc_pwm_n", int'(pwm_n), int'(e_n));
            check("cyc_period_start", int'(period_start), int'(e_ps));
            check("cyc_duty_ready", int'(duty_ready), int'(e_rdy));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input int c, input logic v, input int d);
        count      = c[7:0];
        duty_valid = v;
        duty_in    = d[7:0];
        @(posedge clk);
        #2;
        acc_hi += int'(pwm_out);
        acc_n  += int'(pwm_n);
        acc_ps += int'(period_start);
        duty_valid = 1'b0;
    endtask

    task automatic run(input int from, input int to);
        for (int i = from; i <= to; i++) step(i, 1'b0, 0);
    endtask

    task automatic clr();
        acc_hi = 0;
        acc_n  = 0;
        acc_ps = 0;
    endtask

    task automatic load_at(input int c, input int d);
        run(0, c - 1);
        step(c, 1'b1, d);
        run(c + 1, 255);
        run(0, 255);
    endtask

    initial begin
        reset = 1'b0; count = 8'h00; duty_in = 8'h00; duty_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        cmp_en = 1'b1;
        check("rst_pwm_out", int'(pwm_out), 0);
        check("rst_pwm_n", int'(pwm_n), 0);
        check("rst_ready", int'(duty_ready), 0);
        reset = 1'b1;

        // Reset duty 0x40 from count 0.
        clr(); run(0, 255);
        check("init_first_ps", acc_ps, 0);
        check("init_hi", acc_hi, lit(64));
        check("init_n", acc_n, 192 - DT);
        clr(); run(0, 255);
        check("steady_hi", acc_hi, lit(64));
        check("steady_ps", acc_ps, 1);
        check("steady_ready", int'(duty_ready), 1);

        // Mid-period load of 0x80 at count 0x30.
        clr(); run(0, 8'h2F);
        step(8'h30, 1'b1, 8'h80);
        check("load_ready_fall", int'(duty_ready), 0);
        run(8'h31, 255);
        check("load_old_hi", acc_hi, lit(64));
        clr(); step(0, 1'b0, 0);
        check("load_ready_rise", int'(duty_ready), 1);
        run(1, 255);
        check("load_new_hi", acc_hi, lit(128));
        check("load_ps", acc_ps, 1);

        // Handshake exactly on the boundary, then ignored valid while pending.
        clr(); step(0, 1'b1, 8'h10);
        check("bnd_hs_ready", int'(duty_ready), 0);
        for (int i = 1; i <= 5; i++) step(i, 1'b1, 8'h55);
        check("pend_ready", int'(duty_ready), 0);
        run(6, 255);
        check("bnd_old_duty", acc_hi, lit(128));
        clr(); run(0, 255);
        check("bnd_new16", acc_hi, lit(16));
        clr(); run(0, 255);
        check("pend_ignored", acc_hi, lit(16));

        // Duty extremes and a short phase.
        load_at(8'h20, 8'h00);
        clr(); run(0, 255);
        check("duty0_hi", acc_hi, 0);
        check("duty0_n", acc_n, 256);
        load_at(8'h20, 8'hFF);
        clr(); run(0, 255);
        check("duty255_hi", acc_hi, lit(255));
        check("duty255_n", acc_n, lit(1));
        load_at(8'h20, 8'h03);
        clr(); run(0, 255);
        check("duty3_hi", acc_hi, lit(3));

        // Counter reset mid-count and held at zero: one period_start.
        run(0, 8'h50);
        clr();
        for (int i = 0; i < 10; i++) step(0, 1'b0, 0);
        check("cnt_hold_ps", acc_ps, 1);
        run(1, 255);

        // Reset while pending at count 0x90.
        run(0, 8'h0F);
        step(8'h10, 1'b1, 8'h20);
        run(8'h11, 8'h90);
        check("pre_rst_n", int'(pwm_n), (DT < 8'h8D) ? 1 : 0);
        reset = 1'b0;
        #1;
        check("async_pwm_out", int'(pwm_out), 0);
        check("async_pwm_n", int'(pwm_n), 0);
        check("async_ready", int'(duty_ready), 0);
        check("async_ps", int'(period_start), 0);
        count = 8'h00;
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b1;
        clr(); run(0, 255);
        check("post_rst_ps", acc_ps, 0);
        check("post_rst_hi", acc_hi, lit(64));
        clr(); run(0, 255);
        check("post_rst_discard", acc_hi, lit(64));
        check("post_rst_ps2", acc_ps, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
